// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator dispatcher slice.
// Holds the FSM state encoding, the travel-direction constants and the
// default floor-number width used by the interface, latch and top module.
package elevator_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECIDE = 3'd1,
    MOVE   = 3'd2,
    DOOR   = 3'd3,
    FAULT  = 3'd4
  } state_t;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  localparam int unsigned FLOOR_W = 2;

endpackage

// File: rtl/elevator_dispatcher_if.sv
// Signal bundle between the elevator dispatcher and its environment.
//   FB, CALL   : active-low in-car buttons and hall calls (bit i-1 = floor i)
//   arrived    : one-cycle pulse, one-floor move complete
//   door_done  : one-cycle pulse, door open/close cycle complete
//   move_req   : level, move one floor in direction UD (1 = up)
//   door_req   : level, run one door cycle
//   floor      : current floor, 1..NFLOORS
//   pending    : latched requests
//   busy/fault : status
// modport slave is the dispatcher side, modport master the car/button side.
interface elevator_dispatcher_if
  import elevator_pkg::*;
#(
  parameter int unsigned NFLOORS = 3,
  parameter int unsigned FW      = FLOOR_W
);

  logic [NFLOORS-1:0] FB;
  logic [NFLOORS-1:0] CALL;
  logic               arrived;
  logic               door_done;
  logic               move_req;
  logic               UD;
  logic               door_req;
  logic [FW-1:0]      floor;
  logic [NFLOORS-1:0] pending;
  logic               busy;
  logic               fault;

  modport slave (
    input  FB, CALL, arrived, door_done,
    output move_req, UD, door_req, floor, pending, busy, fault
  );

  modport master (
    output FB, CALL, arrived, door_done,
    input  move_req, UD, door_req, floor, pending, busy, fault
  );

endinterface

// File: rtl/elevator_req_latch.sv
// Pending-request vector for the elevator dispatcher.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   fb, call          : active-low button inputs (bit i-1 = floor i)
//   set_en            : allow new requests to latch
//   drop_here         : discard presses for the current floor
//   clr_en, clr_floor : clear the bit of clr_floor (wins over a same-edge set)
//   floor, ud         : current floor and direction for the reductions
//   pending           : latched request vector
//   above/below/here  : requests relative to the current floor
//   next_here         : request at the adjacent floor in direction ud
//   next_ahead        : request beyond that adjacent floor in direction ud
module elevator_req_latch
  import elevator_pkg::*;
#(
  parameter int unsigned NFLOORS = 3,
  parameter int unsigned FW      = FLOOR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NFLOORS-1:0] fb,
  input  logic [NFLOORS-1:0] call,
  input  logic               set_en,
  input  logic               drop_here,
  input  logic               clr_en,
  input  logic [FW-1:0]      clr_floor,
  input  logic [FW-1:0]      floor,
  input  logic               ud,
  output logic [NFLOORS-1:0] pending,
  output logic               above,
  output logic               below,
  output logic               here,
  output logic               next_here,
  output logic               next_ahead
);

  logic [NFLOORS-1:0] pending_d;

  always_comb begin
    pending_d = pending;
    for (int unsigned i = 0; i < NFLOORS; i++) begin
      if (set_en && (!fb[i] || !call[i]) &&
          !(drop_here && ((i + 1) == 32'(floor))))
        pending_d[i] = 1'b1;
      if (clr_en && ((i + 1) == 32'(clr_floor)))
        pending_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= pending_d;
  end

  // Bit i holds floor i+1; compare floor numbers rather than indices.
  always_comb begin
    above      = 1'b0;
    below      = 1'b0;
    here       = 1'b0;
    next_here  = 1'b0;
    next_ahead = 1'b0;
    for (int unsigned i = 0; i < NFLOORS; i++) begin
      if (pending[i]) begin
        if ((i + 1) >  32'(floor)) above = 1'b1;
        if ((i + 1) <  32'(floor)) below = 1'b1;
        if ((i + 1) == 32'(floor)) here  = 1'b1;
        if (ud == UP) begin
          if ((i + 1) == 32'(floor) + 1) next_here  = 1'b1;
          if ((i + 1) >  32'(floor) + 1) next_ahead = 1'b1;
        end else begin
          if ((i + 2) == 32'(floor)) next_here  = 1'b1;
          if ((i + 2) <  32'(floor)) next_ahead = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/elevator_dispatcher.sv
// SCAN request scheduler for the car: latches requests, picks direction,
// sequences one-floor moves and door cycles, tracks the floor, and faults
// when a move is not acknowledged within MOVE_TIMEOUT cycles.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : elevator_dispatcher_if.slave (buttons, handshakes, status)
module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter int unsigned NFLOORS      = 3,
  parameter int unsigned FW           = FLOOR_W,
  parameter int unsigned MOVE_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  elevator_dispatcher_if.slave  bus
);

  localparam int unsigned   WDW       = $clog2(MOVE_TIMEOUT) + 1;
  localparam logic [FW-1:0] TOP_FLOOR = FW'(NFLOORS);
  localparam logic [FW-1:0] BOT_FLOOR = FW'(1);

  state_t             state_q, state_d;
  logic [FW-1:0]      floor_q, floor_d;
  logic               ud_q, ud_d;
  logic               move_q, move_d;
  logic [WDW-1:0]     wd_q, wd_d;
  logic               clr_en;
  logic [FW-1:0]      clr_floor;
  logic [NFLOORS-1:0] pending;
  logic               above, below, here, next_here, next_ahead;

  elevator_req_latch #(
    .NFLOORS (NFLOORS),
    .FW      (FW)
  ) u_req_latch (
    .clk        (clk),
    .reset      (reset),
    .fb         (bus.FB),
    .call       (bus.CALL),
    .set_en     (state_q != FAULT),
    .drop_here  (state_q == DOOR),
    .clr_en     (clr_en),
    .clr_floor  (clr_floor),
    .floor      (floor_q),
    .ud         (ud_q),
    .pending    (pending),
    .above      (above),
    .below      (below),
    .here       (here),
    .next_here  (next_here),
    .next_ahead (next_ahead)
  );

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    ud_d      = ud_q;
    move_d    = 1'b0;
    wd_d      = '0;
    clr_en    = 1'b0;
    clr_floor = floor_q;
    case (state_q)
      IDLE: begin
        if (here) begin
          state_d = DOOR;
          clr_en  = 1'b1;
        end else if (|pending) begin
          state_d = DECIDE;
        end
      end
      DECIDE: begin
        // Go up if it is ahead, or if it is the only way left; else go down.
        if (here) begin
          state_d = DOOR;
          clr_en  = 1'b1;
        end else if (above && (ud_q == UP || !below)) begin
          state_d = MOVE;
          ud_d    = UP;
          move_d  = 1'b1;
        end else if (below) begin
          state_d = MOVE;
          ud_d    = DOWN;
          move_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      MOVE: begin
        // arrived only counts while a move is actually requested; the
        // one-cycle gap between consecutive moves keeps move_req low.
        if (move_q && bus.arrived) begin
          if ((ud_q == UP && floor_q == TOP_FLOOR) ||
              (ud_q == DOWN && floor_q == BOT_FLOOR)) begin
            state_d = FAULT;
          end else begin
            floor_d = (ud_q == UP) ? floor_q + 1'b1 : floor_q - 1'b1;
            if (next_here) begin
              state_d   = DOOR;
              clr_en    = 1'b1;
              clr_floor = floor_d;
            end else if (!next_ahead) begin
              state_d = DECIDE;
            end
          end
        end else if (wd_q == WDW'(MOVE_TIMEOUT - 1)) begin
          state_d = FAULT;
        end else begin
          move_d = 1'b1;
          wd_d   = wd_q + 1'b1;
        end
      end
      DOOR: begin
        if (bus.door_done) state_d = (|pending) ? DECIDE : IDLE;
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      floor_q <= BOT_FLOOR;
      ud_q    <= UP;
      move_q  <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      ud_q    <= ud_d;
      move_q  <= move_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.move_req = move_q;
  assign bus.UD       = ud_q;
  assign bus.door_req = (state_q == DOOR);
  assign bus.floor    = floor_q;
  assign bus.pending  = pending;
  assign bus.busy     = (state_q != IDLE);
  assign bus.fault    = (state_q == FAULT);

endmodule
